xram_bridge: RTL and testbench
==============================

Name: xram_bridge

Overview:
- Second-generation MCU external-data-memory bridge between the 8051-style core's MOVX port and two targets:
  - the local data RAM (DRAM);
  - the register access bus (RAB), which is arbitrated and slow.
- Adds over the first generation:
  - parametrised address map and widths;
  - a registered, wait-state handshake to the MCU (mem_wait);
  - multi-cycle RAB transactions held until ack;
  - RAB timeout;
  - a sticky bus-error flag for unmapped or timed-out accesses.
- Sits between the MCU core and the DRAM macro / RAB arbiter.

Parameters:
- DRAM_ADDR_WIDTH, 12, DRAM word address width; DRAM window = DRAM_BASE .. DRAM_BASE+2^DRAM_ADDR_WIDTH-1.
- DRAM_BASE, 16'h0000, DRAM window base; aligned to 2^DRAM_ADDR_WIDTH.
- RAB_ADDR_WIDTH, 9, RAB register address width.
- REG_BASE, 16'hFE00, RAB window base; aligned to 2^RAB_ADDR_WIDTH.
- DRAM_RD_LAT, 1, DRAM read latency in cycles (1..4).
- RAB_TIMEOUT, 64, maximum cycles a RAB strobe is held waiting for ack (2..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active low
- memaddr  in  16  MCU MOVX address
- memwr  in  1  MCU write strobe, one-cycle pulse
- memrd  in  1  MCU read strobe, one-cycle pulse
- xram_wdata  in  8  MCU write data
- xram_rdata  out  8  read data to MCU, registered
- mem_wait  out  1  stall request to MCU
- bus_err  out  1  sticky error flag
- bus_err_clr  in  1  clears bus_err
- dram_rdata  in  8  DRAM read data
- dram_wdata  out  8  DRAM write data
- dram_addr  out  DRAM_ADDR_WIDTH  DRAM address
- dram_wr  out  1  DRAM write pulse
- dram_rd  out  1  DRAM read pulse
- mcu_rab_ack  in  1  RAB transaction acknowledge
- mcu_rab_rdata  in  8  RAB read data
- mcu_rab_wdata  out  8  RAB write data, latched
- mcu_rab_addr  out  RAB_ADDR_WIDTH  RAB address, latched
- mcu_rab_write  out  1  RAB write request, level
- mcu_rab_read  out  1  RAB read request, level

Behaviour:

Reset values (all outputs and internal registers):
- xram_rdata = 8'h00; all strobes = 0; mem_wait = 0; bus_err = 0; mcu_rab_addr = 0; mcu_rab_wdata = 0.
- State = IDLE.

Request acceptance:
- A request is accepted only in IDLE, when memrd|memwr = 1.
- memaddr and xram_wdata are sampled in the accept cycle T.
- memrd and memwr both high: treated as a write; bus_err is set.
- Strobes arriving while not in IDLE are a protocol violation. They are ignored and set bus_err.

Decode (in cycle T):
- DRAM hit: memaddr in the DRAM window.
- REG hit: memaddr in the RAB window.
- Otherwise unmapped.

mem_wait:
- Combinationally high in T for any DRAM read or RAB access.
- Registered high afterwards until completion.
- The MCU samples xram_rdata in the first cycle with mem_wait = 0.

State machine (IDLE, DRD, RAB, DONE):
- IDLE + DRAM write:
  - dram_wr = 1, dram_wdata = xram_wdata, dram_addr = memaddr low bits, all combinational in T.
  - No wait state; stays IDLE.
- IDLE + DRAM read:
  - dram_rd = 1 in T; go to DRD with latency counter = DRAM_RD_LAT.
  - In DRD, capture dram_rdata into xram_rdata at the end of cycle T+DRAM_RD_LAT.
  - mem_wait is high in cycles T..T+DRAM_RD_LAT and low from T+DRAM_RD_LAT+1.
- IDLE + REG hit:
  - Latch address and data; go to RAB.
  - mcu_rab_read/mcu_rab_write are registered and held from T+1 until ack.
  - On mcu_rab_ack = 1 in cycle A: capture mcu_rab_rdata (reads only), drop the strobe, go to DONE.
  - mem_wait is low from A+1.
  - An ack in the same cycle the strobe first rises is valid.
- RAB timeout:
  - Timeout counter starts at 0 at T+1 and increments each RAB cycle without ack.
  - When it reaches RAB_TIMEOUT-1 with no ack: drop the strobe, xram_rdata = 8'hFF (reads), set bus_err, go to DONE.
  - An ack in that same cycle wins; no error.
- DONE: one cycle, mem_wait = 0, then IDLE.
  - Back-to-back requests therefore see at least one idle cycle after a RAB access.
- IDLE + unmapped:
  - Write is discarded.
  - Read loads xram_rdata = 8'hFF at the end of T. mem_wait is high in T only.
  - bus_err is set in both cases.

Other rules:
- mcu_rab_ack outside the RAB state is ignored.
- dram_wr and dram_rd are never asserted outside a DRAM hit.
- bus_err priority: set beats clear when both occur in the same cycle.
- rst asserted mid-operation: everything returns to reset values asynchronously and the pending access is dropped. No ack is expected afterwards.

Decomposition:
- Package xram_bridge_pkg holds:
  - state encoding localparams;
  - the default address-map constants: DRAM_BASE, REG_BASE, widths, and the error read value 8'hFF.
- Sub-module xram_bridge_timer:
  - loadable down-counter with a zero flag;
  - reused for both the DRAM latency count and the RAB timeout.

Test Plan:
- Write 8'hA5 to 16'h0123, then read 16'h0123 with DRAM_RD_LAT = 1:
  - write: dram_wr pulse in T, addr 12'h123, no mem_wait;
  - read: mem_wait for 2 cycles, xram_rdata = 8'hA5.
- Read 16'hFE10; RAB model acks 3 cycles after the strobe with 8'h3C:
  - mcu_rab_read held 4 cycles, mcu_rab_addr = 9'h010;
  - xram_rdata = 8'h3C; mem_wait falls the cycle after ack.
- RAB write to 16'hFFFF with no ack, RAB_TIMEOUT = 8:
  - strobe held 8 cycles, then drops;
  - bus_err = 1; bus_err_clr clears it.
- Read of unmapped 16'h8000:
  - xram_rdata = 8'hFF; no DRAM or RAB strobe; bus_err = 1.
- Assert rst in the middle of a RAB read:
  - all outputs reset immediately;
  - a late ack after reset is ignored; the next request proceeds normally.
- memrd and memwr pulsed together at 16'h0010:
  - DRAM write performed; bus_err = 1.

Source files
------------

// File: rtl/xram_bridge_pkg.sv
// Shared state encoding, default address map and decode helper for the
// MOVX-to-DRAM/RAB bridge.
package xram_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRD  = 2'd1,
      ST_RAB  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int unsigned XB_DRAM_ADDR_WIDTH = 12;
   localparam logic [15:0] XB_DRAM_BASE       = 16'h0000;
   localparam int unsigned XB_RAB_ADDR_WIDTH  = 9;
   localparam logic [15:0] XB_REG_BASE        = 16'hFE00;
   localparam int unsigned XB_DRAM_RD_LAT     = 1;
   localparam int unsigned XB_RAB_TIMEOUT     = 64;
   localparam logic [7:0]  XB_ERR_RDATA       = 8'hFF;

   // Windows are aligned to their size, so a hit is "upper bits equal".
   function automatic logic in_window(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input int unsigned width);
      return ((addr ^ base) >> width) == 16'h0000;
   endfunction

endpackage

// File: rtl/xram_bridge_timer.sv
// Loadable saturating down-counter with a zero flag; times both the DRAM
// read latency and the RAB ack timeout.
module xram_bridge_timer
   import xram_bridge_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: load wins over decrement, decrement stops at zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != W'(0))) begin
         count_d = count_q - W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= W'(0);
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == W'(0));

endmodule

// File: rtl/xram_bridge.sv
// MOVX bridge from the MCU core to local DRAM and the arbitrated register
// access bus, with wait-state handshake, RAB timeout and sticky bus error.
module xram_bridge
   import xram_bridge_pkg::*;
#(
   parameter int unsigned DRAM_ADDR_WIDTH = XB_DRAM_ADDR_WIDTH,
   parameter logic [15:0] DRAM_BASE       = XB_DRAM_BASE,
   parameter int unsigned RAB_ADDR_WIDTH  = XB_RAB_ADDR_WIDTH,
   parameter logic [15:0] REG_BASE        = XB_REG_BASE,
   parameter int unsigned DRAM_RD_LAT     = XB_DRAM_RD_LAT,
   parameter int unsigned RAB_TIMEOUT     = XB_RAB_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [15:0]                memaddr,
   input  logic                       memwr,
   input  logic                       memrd,
   input  logic [7:0]                 xram_wdata,
   output logic [7:0]                 xram_rdata,
   output logic                       mem_wait,
   output logic                       bus_err,
   input  logic                       bus_err_clr,
   input  logic [7:0]                 dram_rdata,
   output logic [7:0]                 dram_wdata,
   output logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
   output logic                       dram_wr,
   output logic                       dram_rd,
   input  logic                       mcu_rab_ack,
   input  logic [7:0]                 mcu_rab_rdata,
   output logic [7:0]                 mcu_rab_wdata,
   output logic [RAB_ADDR_WIDTH-1:0]  mcu_rab_addr,
   output logic                       mcu_rab_write,
   output logic                       mcu_rab_read
);

   localparam logic [7:0] LAT_LOAD = 8'(DRAM_RD_LAT - 1);
   localparam logic [7:0] TMO_LOAD = 8'(RAB_TIMEOUT - 1);

   state_t                      state_q, state_d;
   logic [7:0]                  rdata_q, rdata_d;
   logic                        err_q, err_d;
   logic [RAB_ADDR_WIDTH-1:0]   rab_addr_q, rab_addr_d;
   logic [7:0]                  rab_wdata_q, rab_wdata_d;
   logic                        rab_rd_q, rab_rd_d;
   logic                        rab_wr_q, rab_wr_d;
   logic [DRAM_ADDR_WIDTH-1:0]  dram_addr_q, dram_addr_d;

   logic       req_s;
   logic       dram_hit_s;
   logic       reg_hit_s;
   logic       err_set_s;
   logic       wait_s;
   logic       dram_wr_s;
   logic       dram_rd_s;
   logic       tmr_load_s;
   logic [7:0] tmr_val_s;
   logic       tmr_dec_s;
   logic       tmr_zero_s;

   assign req_s      = memrd | memwr;
   assign dram_hit_s = in_window(memaddr, DRAM_BASE, DRAM_ADDR_WIDTH);
   assign reg_hit_s  = in_window(memaddr, REG_BASE, RAB_ADDR_WIDTH);

   xram_bridge_timer #(.W(8)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load_s),
      .load_val_i (tmr_val_s),
      .dec_i      (tmr_dec_s),
      .zero_o     (tmr_zero_s)
   );

   // Next-state, capture and strobe decode; simultaneous rd+wr is a write.
   always_comb begin
      state_d     = state_q;
      rdata_d     = rdata_q;
      rab_addr_d  = rab_addr_q;
      rab_wdata_d = rab_wdata_q;
      rab_rd_d    = rab_rd_q;
      rab_wr_d    = rab_wr_q;
      dram_addr_d = dram_addr_q;
      err_set_s   = 1'b0;
      wait_s      = 1'b0;
      dram_wr_s   = 1'b0;
      dram_rd_s   = 1'b0;
      tmr_load_s  = 1'b0;
      tmr_val_s   = 8'h00;
      tmr_dec_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               err_set_s = memrd & memwr;
               if (dram_hit_s) begin
                  dram_addr_d = memaddr[DRAM_ADDR_WIDTH-1:0];
                  if (memwr) begin
                     dram_wr_s = 1'b1;
                  end else begin
                     dram_rd_s  = 1'b1;
                     wait_s     = 1'b1;
                     tmr_load_s = 1'b1;
                     tmr_val_s  = LAT_LOAD;
                     state_d    = ST_DRD;
                  end
               end else if (reg_hit_s) begin
                  rab_addr_d  = memaddr[RAB_ADDR_WIDTH-1:0];
                  rab_wdata_d = xram_wdata;
                  rab_wr_d    = memwr;
                  rab_rd_d    = ~memwr;
                  wait_s      = 1'b1;
                  tmr_load_s  = 1'b1;
                  tmr_val_s   = TMO_LOAD;
                  state_d     = ST_RAB;
               end else begin
                  err_set_s = 1'b1;
                  if (!memwr) begin
                     rdata_d = XB_ERR_RDATA;
                     wait_s  = 1'b1;
                  end else begin
                     rdata_d = rdata_q;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRD: begin
            wait_s    = 1'b1;
            tmr_dec_s = 1'b1;
            err_set_s = req_s;
            if (tmr_zero_s) begin
               rdata_d = dram_rdata;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRD;
            end
         end
         ST_RAB: begin
            wait_s    = 1'b1;
            err_set_s = req_s;
            // An ack arriving together with the timeout still completes cleanly.
            if (mcu_rab_ack) begin
               if (rab_rd_q) begin
                  rdata_d = mcu_rab_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
               rab_rd_d = 1'b0;
               rab_wr_d = 1'b0;
               state_d  = ST_DONE;
            end else if (tmr_zero_s) begin
               if (rab_rd_q) begin
                  rdata_d = XB_ERR_RDATA;
               end else begin
                  rdata_d = rdata_q;
               end
               rab_rd_d  = 1'b0;
               rab_wr_d  = 1'b0;
               err_set_s = 1'b1;
               state_d   = ST_DONE;
            end else begin
               tmr_dec_s = 1'b1;
            end
         end
         ST_DONE: begin
            err_set_s = req_s;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      err_d = err_set_s | (err_q & ~bus_err_clr);
   end

   // Bridge state and latched transaction registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         rdata_q     <= 8'h00;
         err_q       <= 1'b0;
         rab_addr_q  <= '0;
         rab_wdata_q <= 8'h00;
         rab_rd_q    <= 1'b0;
         rab_wr_q    <= 1'b0;
         dram_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         rab_addr_q  <= rab_addr_d;
         rab_wdata_q <= rab_wdata_d;
         rab_rd_q    <= rab_rd_d;
         rab_wr_q    <= rab_wr_d;
         dram_addr_q <= dram_addr_d;
      end
   end

   assign xram_rdata    = rdata_q;
   assign mem_wait      = wait_s;
   assign bus_err       = err_q;
   assign dram_wdata    = xram_wdata;
   assign dram_addr     = (state_q == ST_IDLE) ? memaddr[DRAM_ADDR_WIDTH-1:0] : dram_addr_q;
   assign dram_wr       = dram_wr_s;
   assign dram_rd       = dram_rd_s;
   assign mcu_rab_wdata = rab_wdata_q;
   assign mcu_rab_addr  = rab_addr_q;
   assign mcu_rab_write = rab_wr_q;
   assign mcu_rab_read  = rab_rd_q;

endmodule

// File: tb/tb_xram_bridge.sv
// Self-checking bench for xram_bridge: directed vector table, hand-written
// reset/protocol sequences and randomized traffic against a transaction model.
module tb_xram_bridge;

   localparam int TO  = 8;
   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] memaddr;
   logic        memwr, memrd;
   logic [7:0]  xram_wdata, xram_rdata;
   logic        mem_wait, bus_err, bus_err_clr;
   logic [7:0]  dram_rdata, dram_wdata;
   logic [11:0] dram_addr;
   logic        dram_wr, dram_rd;
   logic        mcu_rab_ack;
   logic [7:0]  mcu_rab_rdata, mcu_rab_wdata;
   logic [8:0]  mcu_rab_addr;
   logic        mcu_rab_write, mcu_rab_read;

   int checks = 0;
   int failures = 0;

   xram_bridge #(.DRAM_RD_LAT(LAT), .RAB_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .memaddr(memaddr), .memwr(memwr), .memrd(memrd),
      .xram_wdata(xram_wdata), .xram_rdata(xram_rdata), .mem_wait(mem_wait),
      .bus_err(bus_err), .bus_err_clr(bus_err_clr), .dram_rdata(dram_rdata),
      .dram_wdata(dram_wdata), .dram_addr(dram_addr), .dram_wr(dram_wr),
      .dram_rd(dram_rd), .mcu_rab_ack(mcu_rab_ack), .mcu_rab_rdata(mcu_rab_rdata),
      .mcu_rab_wdata(mcu_rab_wdata), .mcu_rab_addr(mcu_rab_addr),
      .mcu_rab_write(mcu_rab_write), .mcu_rab_read(mcu_rab_read)
   );

   always #5 clk = ~clk;

   // DRAM macro: synchronous, one cycle read latency.
   bit [7:0] dmem [4096];
   always @(posedge clk) begin
      if (dram_wr) dmem[dram_addr] <= dram_wdata;
      if (dram_rd) dram_rdata <= dmem[dram_addr];
   end

   // RAB responder: acks rab_delay cycles after the strobe rises.
   int         rab_delay = 1000;
   int         rab_cnt = 0;
   logic [7:0] rab_data = 8'h00;
   logic       resp_ack = 1'b0;
   logic       force_ack = 1'b0;
   always @(negedge clk) begin
      if (mcu_rab_read || mcu_rab_write) begin
         rab_cnt  <= rab_cnt + 1;
         resp_ack <= (rab_cnt + 1 == rab_delay + 1);
      end else begin
         rab_cnt  <= 0;
         resp_ack <= 1'b0;
      end
   end
   assign mcu_rab_ack   = resp_ack | force_ack;
   assign mcu_rab_rdata = rab_data;

   // Transaction-level reference state.
   bit [7:0]   ref_mem [4096];
   logic [7:0] ref_rdata = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // op: 0 read, 1 write, 2 read+write together (behaves as write, flags error)
   task automatic model(input logic [15:0] a, input int op, input logic [7:0] wd,
                        input int dly, input logic [7:0] rdv,
                        output int waits, output int strobes, output int drd,
                        output int dwr, output logic [7:0] rdat, output logic err);
      bit is_wr;
      is_wr = (op != 0);
      err = (op == 2);
      waits = 0; strobes = 0; drd = 0; dwr = 0;
      if (a < 16'h1000) begin
         if (is_wr) begin
            ref_mem[a[11:0]] = wd;
            dwr = 1;
         end else begin
            drd = 1;
            waits = LAT + 1;
            ref_rdata = ref_mem[a[11:0]];
         end
      end else if (a >= 16'hFE00) begin
         strobes = (dly + 1 <= TO) ? dly + 1 : TO;
         waits = strobes + 1;
         if (dly + 1 > TO) begin
            err = 1'b1;
            if (!is_wr) ref_rdata = 8'hFF;
         end else if (!is_wr) begin
            ref_rdata = rdv;
         end
      end else begin
         err = 1'b1;
         if (!is_wr) begin
            ref_rdata = 8'hFF;
            waits = 1;
         end
      end
      rdat = ref_rdata;
   endtask

   task automatic run_txn(input logic [15:0] a, input int op, input logic [7:0] wd,
                          input int dly, input logic [7:0] rdv,
                          output int waits, output int strobes, output int drd,
                          output int dwr, output logic [7:0] rdat, output logic err,
                          output logic [8:0] rab_a, output logic [7:0] rab_wd,
                          output logic [11:0] dram_a);
      int n;
      bit busy;
      rab_delay = dly;
      rab_data  = rdv;
      waits = 0; strobes = 0; drd = 0; dwr = 0; rab_a = '0; rab_wd = '0;
      @(negedge clk);
      memaddr = a; memrd = (op != 1); memwr = (op != 0); xram_wdata = wd;
      #1;
      busy = mem_wait;
      if (mem_wait) waits++;
      if (dram_rd) drd++;
      if (dram_wr) dwr++;
      dram_a = dram_addr;
      @(negedge clk);
      memrd = 1'b0; memwr = 1'b0;
      #1;
      n = 0;
      while (busy) begin
         if (mcu_rab_read || mcu_rab_write) begin
            strobes++;
            rab_a  = mcu_rab_addr;
            rab_wd = mcu_rab_wdata;
         end
         if (dram_rd) drd++;
         if (dram_wr) dwr++;
         if (!mem_wait) begin
            busy = 1'b0;
         end else begin
            waits++;
            n++;
            if (n > 200) begin
               chk("wait_bound", n, 200);
               busy = 1'b0;
            end else begin
               @(negedge clk);
               #1;
            end
         end
      end
      rdat = xram_rdata;
      err  = bus_err;
   endtask

   task automatic clear_err();
      bus_err_clr = 1'b1;
      @(negedge clk);
      bus_err_clr = 1'b0;
      #1;
      chk("err_clr", bus_err, 1'b0);
   endtask

   typedef struct {
      logic [15:0] addr;
      int          op;
      logic [7:0]  wd;
      int          dly;
      logic [7:0]  rdv;
      int          e_waits;
      int          e_strobes;
      int          e_drd;
      int          e_dwr;
      logic [7:0]  e_rdata;
      logic        e_err;
   } vec_t;

   initial begin
      vec_t vt[15];
      int ow, os, odr, odw, mw, ms, mdr, mdw;
      logic [7:0] ord, mrd, orwd;
      logic oerr, merr;
      logic [8:0] ora;
      logic [11:0] oda;
      logic [15:0] ra;
      int rop, rdl, cat;
      logic [7:0] rwd, rrv;

      //           addr     op wd     dly rdv    waits strb drd dwr rdata  err
      vt[0]  = '{16'h0123, 1, 8'hA5, 0,  8'h00, 0,    0,   0,  1,  8'h00, 1'b0};
      vt[1]  = '{16'h0123, 0, 8'h00, 0,  8'h00, 2,    0,   1,  0,  8'hA5, 1'b0};
      vt[2]  = '{16'hFE10, 0, 8'h00, 3,  8'h3C, 5,    4,   0,  0,  8'h3C, 1'b0};
      vt[3]  = '{16'hFFFF, 1, 8'hC3, 99, 8'h00, 9,    8,   0,  0,  8'h3C, 1'b1};
      vt[4]  = '{16'h8000, 0, 8'h00, 0,  8'h00, 1,    0,   0,  0,  8'hFF, 1'b1};
      vt[5]  = '{16'h0010, 2, 8'h5A, 0,  8'h00, 0,    0,   0,  1,  8'hFF, 1'b1};
      vt[6]  = '{16'h0010, 0, 8'h00, 0,  8'h00, 2,    0,   1,  0,  8'h5A, 1'b0};
      vt[7]  = '{16'hFE00, 0, 8'h00, 0,  8'h11, 2,    1,   0,  0,  8'h11, 1'b0};
      vt[8]  = '{16'hFE01, 0, 8'h00, 7,  8'h22, 9,    8,   0,  0,  8'h22, 1'b0};
      vt[9]  = '{16'hFE02, 0, 8'h00, 8,  8'h33, 9,    8,   0,  0,  8'hFF, 1'b1};
      vt[10] = '{16'h0FFF, 1, 8'h77, 0,  8'h00, 0,    0,   0,  1,  8'hFF, 1'b0};
      vt[11] = '{16'h1000, 0, 8'h00, 0,  8'h00, 1,    0,   0,  0,  8'hFF, 1'b1};
      vt[12] = '{16'h0FFF, 0, 8'h00, 0,  8'h00, 2,    0,   1,  0,  8'h77, 1'b0};
      vt[13] = '{16'hFDFF, 0, 8'h00, 0,  8'h00, 1,    0,   0,  0,  8'hFF, 1'b1};
      vt[14] = '{16'hFE05, 2, 8'h9C, 2,  8'h44, 4,    3,   0,  0,  8'hFF, 1'b1};

      rst = 1'b0; memaddr = 16'h0000; memwr = 1'b0; memrd = 1'b0;
      xram_wdata = 8'h00; bus_err_clr = 1'b0;
      @(negedge clk); @(negedge clk);
      #1;
      chk("rst_rdata", xram_rdata, 8'h00);
      chk("rst_wait", mem_wait, 1'b0);
      chk("rst_err", bus_err, 1'b0);
      chk("rst_strobes", {mcu_rab_read, mcu_rab_write, dram_rd, dram_wr}, 4'h0);
      chk("rst_rab_addr", mcu_rab_addr, 9'h000);
      chk("rst_rab_wdata", mcu_rab_wdata, 8'h00);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 15; i++) begin
         run_txn(vt[i].addr, vt[i].op, vt[i].wd, vt[i].dly, vt[i].rdv,
                 ow, os, odr, odw, ord, oerr, ora, orwd, oda);
         model(vt[i].addr, vt[i].op, vt[i].wd, vt[i].dly, vt[i].rdv,
               mw, ms, mdr, mdw, mrd, merr);
         chk($sformatf("v%0d_waits", i), ow, vt[i].e_waits);
         chk($sformatf("v%0d_strobes", i), os, vt[i].e_strobes);
         chk($sformatf("v%0d_dram_rd", i), odr, vt[i].e_drd);
         chk($sformatf("v%0d_dram_wr", i), odw, vt[i].e_dwr);
         chk($sformatf("v%0d_rdata", i), ord, vt[i].e_rdata);
         chk($sformatf("v%0d_err", i), oerr, vt[i].e_err);
         if (vt[i].e_drd + vt[i].e_dwr > 0)
            chk($sformatf("v%0d_dram_addr", i), oda, vt[i].addr[11:0]);
         if (vt[i].e_strobes > 0)
            chk($sformatf("v%0d_rab_addr", i), ora, vt[i].addr[8:0]);
         if (vt[i].e_strobes > 0 && vt[i].op != 0)
            chk($sformatf("v%0d_rab_wdata", i), orwd, vt[i].wd);
         clear_err();
      end

      // Reset in the middle of a RAB read, then a stray ack.
      rab_delay = 1000;
      @(negedge clk);
      memaddr = 16'hFE20; memrd = 1'b1;
      @(negedge clk);
      memrd = 1'b0;
      @(negedge clk); @(negedge clk);
      #1;
      chk("mid_rab_strobe", mcu_rab_read, 1'b1);
      rst = 1'b0;
      #1;
      chk("mid_rst_strobe", {mcu_rab_read, mcu_rab_write}, 2'b00);
      chk("mid_rst_wait", mem_wait, 1'b0);
      chk("mid_rst_addr", mcu_rab_addr, 9'h000);
      chk("mid_rst_rdata", xram_rdata, 8'h00);
      ref_rdata = 8'h00;
      @(negedge clk);
      rst = 1'b1; force_ack = 1'b1;
      #1;
      chk("late_ack_wait", mem_wait, 1'b0);
      @(negedge clk);
      force_ack = 1'b0;
      #1;
      chk("late_ack_err", bus_err, 1'b0);
      chk("late_ack_rdata", xram_rdata, 8'h00);
      run_txn(16'hFE30, 0, 8'h00, 1, 8'h5E, ow, os, odr, odw, ord, oerr, ora, orwd, oda);
      model(16'hFE30, 0, 8'h00, 1, 8'h5E, mw, ms, mdr, mdw, mrd, merr);
      chk("post_rst_rdata", ord, mrd);
      chk("post_rst_strobes", os, ms);
      chk("post_rst_err", oerr, merr);
      clear_err();

      // Strobe during a busy RAB read: ignored but flagged.
      rab_delay = 4; rab_data = 8'h66;
      @(negedge clk);
      memaddr = 16'hFE40; memrd = 1'b1;
      @(negedge clk);
      memrd = 1'b0;
      @(negedge clk);
      memaddr = 16'h8000; memrd = 1'b1;
      @(negedge clk);
      memrd = 1'b0;
      #1;
      for (int n = 0; n < 20 && mem_wait; n++) begin
         @(negedge clk);
         #1;
      end
      chk("busy_wait_done", mem_wait, 1'b0);
      chk("busy_rdata", xram_rdata, 8'h66);
      chk("busy_err", bus_err, 1'b1);
      chk("busy_rab_addr", mcu_rab_addr, 9'h040);
      ref_rdata = 8'h66;
      clear_err();

      // Set beats clear in the same cycle.
      @(negedge clk);
      memaddr = 16'h8000; memwr = 1'b1; bus_err_clr = 1'b1;
      @(negedge clk);
      memwr = 1'b0; bus_err_clr = 1'b0;
      #1;
      chk("set_beats_clr", bus_err, 1'b1);
      clear_err();

      // Randomized traffic against the transaction model.
      for (int i = 0; i < 60; i++) begin
         cat = int'($urandom_range(0, 2));
         if (cat == 0)      ra = 16'(16'h0000 + $urandom_range(0, 15));
         else if (cat == 1) ra = 16'(16'hFE00 + $urandom_range(0, 511));
         else               ra = 16'(16'h1000 + $urandom_range(0, 16'hEDFF));
         rop = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
         rdl = int'($urandom_range(0, 9));
         rwd = 8'($urandom);
         rrv = 8'($urandom);
         run_txn(ra, rop, rwd, rdl, rrv, ow, os, odr, odw, ord, oerr, ora, orwd, oda);
         model(ra, rop, rwd, rdl, rrv, mw, ms, mdr, mdw, mrd, merr);
         chk($sformatf("r%0d_waits", i), ow, mw);
         chk($sformatf("r%0d_strobes", i), os, ms);
         chk($sformatf("r%0d_dram", i), {odr[7:0], odw[7:0]}, {mdr[7:0], mdw[7:0]});
         chk($sformatf("r%0d_rdata", i), ord, mrd);
         chk($sformatf("r%0d_err", i), oerr, merr);
         clear_err();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
